kpn_fifo_arbiter: RTL and testbench

Four-way round-robin write arbiter and read gate for one `fifo_module` channel (2**FIFO_ELEMENTS words, BITS_NUMBER bits wide) in the KPN fabric.
- Merges four producer processes onto the FIFO's single `wr`/`entry_1` port, with per-owner bursts.
- Gates the consumer's read requests.
- Keeps a shadow occupancy count, because the FIFO exposes no full/empty flags.
- Guarantees the FIFO never sees a write while full or a read while empty, including the simultaneous write+read case, where the FIFO advances both pointers unconditionally.

---
 rtl/kpn_fifo_arbiter.sv | 172 +++++++++++++++++
 tb/tb_kpn_fifo_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kpn_fifo_arbiter.sv
// kpn_fifo_arbiter
// Four-way round-robin write arbiter and read gate for one fifo_module channel.
// Producers are merged onto the FIFO write port with per-owner bursts of up to
// MAX_BURST words. The consumer's read requests are gated against a shadow
// occupancy count, because the FIFO has no full/empty flags of its own.
//
// State table (r_st):
//   ST_IDLE | no owner; the round-robin scan starting at r_rr_ptr picks the candidate
//   ST_OWN  | r_owner holds the write port while it keeps requesting, up to MAX_BURST words
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high
//   req         in   [3:0] producer i has a word on its slice of entries
//   entries     in   [4*BITS_NUMBER-1:0] producer i data at [i*BITS_NUMBER +: BITS_NUMBER]
//   grant       out  [3:0] one-hot, combinational; the word is accepted at this edge
//   cons_rd     in   consumer requests one word
//   fifo_rd     out  combinational FIFO rd, also the consumer acknowledge
//   fifo_wr     out  registered FIFO wr
//   fifo_entry  out  [BITS_NUMBER-1:0] registered FIFO entry_1
//   count       out  [FIFO_ELEMENTS:0] words currently stored in the FIFO
//   full        out  combinational; no word can be accepted this cycle
//   empty       out  combinational; count == 0
module kpn_fifo_arbiter #(
    parameter int BITS_NUMBER   = 16,
    parameter int FIFO_ELEMENTS = 5,
    parameter int MAX_BURST     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 req,
    input  logic [4*BITS_NUMBER-1:0]   entries,
    output logic [3:0]                 grant,
    input  logic                       cons_rd,
    output logic                       fifo_rd,
    output logic                       fifo_wr,
    output logic [BITS_NUMBER-1:0]     fifo_entry,
    output logic [FIFO_ELEMENTS:0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int DEPTH = 2**FIFO_ELEMENTS;
    localparam logic [FIFO_ELEMENTS+1:0] DEPTH_W = (FIFO_ELEMENTS+2)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t                    r_st;
    state_t                    w_st_nxt;
    logic [1:0]                r_owner;
    logic [1:0]                w_owner_nxt;
    logic [1:0]                r_rr_ptr;
    logic [1:0]                w_rr_nxt;
    logic [3:0]                r_burst_cnt;
    logic [3:0]                w_burst_nxt;
    logic [3:0]                w_burst_inc;
    logic                      r_fifo_wr;
    logic [BITS_NUMBER-1:0]    r_fifo_entry;
    logic [FIFO_ELEMENTS:0]    r_count;

    logic [FIFO_ELEMENTS+1:0]  w_occ_pending;
    logic                      w_space;
    logic                      w_keep_owner;
    logic [7:0]                w_req_dbl;
    logic [3:0]                w_req_rot;
    logic [1:0]                w_rot_off;
    logic                      w_cand_vld;
    logic [1:0]                w_cand;
    logic                      w_accept;
    logic [BITS_NUMBER-1:0]    w_cand_data;

    // A word in flight on fifo_wr is counted as occupied; a same-cycle read
    // is deliberately not credited, so the write side never races the read.
    assign w_occ_pending = {1'b0, r_count} + {{(FIFO_ELEMENTS+1){1'b0}}, r_fifo_wr};
    assign w_space       = w_occ_pending < DEPTH_W;
    assign full          = ~w_space;
    assign empty         = (r_count == '0);

    // In-flight words are not yet readable, so only the committed count gates reads.
    assign fifo_rd       = ~reset & cons_rd & (r_count != '0);

    assign fifo_wr       = r_fifo_wr;
    assign fifo_entry    = r_fifo_entry;
    assign count         = r_count;

    // Rotate the request vector so bit 0 is the producer at r_rr_ptr; the
    // lowest set bit is then the next producer in round-robin order.
    assign w_req_dbl     = {req, req};
    assign w_req_rot     = w_req_dbl[r_rr_ptr +: 4];
    assign w_keep_owner  = (r_st == ST_OWN) && req[r_owner];
    assign w_burst_inc   = r_burst_cnt + 4'd1;

    always_comb begin
        w_rot_off  = 2'd0;
        w_cand_vld = 1'b0;
        w_cand     = r_owner;
        if (w_req_rot[0])      w_rot_off = 2'd0;
        else if (w_req_rot[1]) w_rot_off = 2'd1;
        else if (w_req_rot[2]) w_rot_off = 2'd2;
        else                   w_rot_off = 2'd3;
        if (w_keep_owner) begin
            w_cand     = r_owner;
            w_cand_vld = 1'b1;
        end else if (req != 4'b0000) begin
            w_cand     = r_rr_ptr + w_rot_off;
            w_cand_vld = 1'b1;
        end
    end

    assign w_accept    = w_cand_vld & w_space;
    assign w_cand_data = entries[w_cand*BITS_NUMBER +: BITS_NUMBER];
    assign grant       = (w_accept && !reset) ? (4'b0001 << w_cand) : 4'b0000;

    always_comb begin
        w_st_nxt    = r_st;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst_cnt;
        w_rr_nxt    = r_rr_ptr;
        if (w_keep_owner) begin
            // A stalled owner keeps its burst position.
            if (w_accept) begin
                w_burst_nxt = w_burst_inc;
                if (w_burst_inc == 4'(MAX_BURST)) begin
                    w_st_nxt = ST_IDLE;
                    w_rr_nxt = r_owner + 2'd1;
                end
            end
        end else begin
            // Either idle or the owner just dropped req: give the port away this cycle.
            w_st_nxt = ST_IDLE;
            if (w_accept) begin
                w_owner_nxt = w_cand;
                w_burst_nxt = 4'd1;
                w_rr_nxt    = w_cand + 2'd1;
                w_st_nxt    = (MAX_BURST > 1) ? ST_OWN : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st        <= ST_IDLE;
            r_owner     <= 2'd0;
            r_burst_cnt <= 4'd0;
            r_rr_ptr    <= 2'd0;
        end else begin
            r_st        <= w_st_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rr_ptr    <= w_rr_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_wr    <= 1'b0;
            r_fifo_entry <= '0;
            r_count      <= '0;
        end else begin
            r_fifo_wr <= w_accept;
            if (w_accept) begin
                r_fifo_entry <= w_cand_data;
            end
            r_count <= r_count + {{FIFO_ELEMENTS{1'b0}}, r_fifo_wr}
                               - {{FIFO_ELEMENTS{1'b0}}, fifo_rd};
        end
    end

endmodule

// File: tb/tb_kpn_fifo_arbiter.sv
module tb_kpn_fifo_arbiter;

    localparam int BN    = 16;
    localparam int FE    = 5;
    localparam int MAXB  = 4;
    localparam int DEPTH = 32;

    logic            clk;
    logic            reset;
    logic [3:0]      req;
    logic [4*BN-1:0] entries;
    logic [3:0]      grant;
    logic            cons_rd;
    logic            fifo_rd;
    logic            fifo_wr;
    logic [BN-1:0]   fifo_entry;
    logic [FE:0]     count;
    logic            full;
    logic            empty;

    int n_cmp  = 0;
    int n_fail = 0;

    kpn_fifo_arbiter #(.BITS_NUMBER(BN), .FIFO_ELEMENTS(FE), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .entries    (entries),
        .grant      (grant),
        .cons_rd    (cons_rd),
        .fifo_rd    (fifo_rd),
        .fifo_wr    (fifo_wr),
        .fifo_entry (fifo_entry),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 3 units after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 4'b0000;
        cons_rd = 1'b0;
        entries = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        cons_rd = 1'b1;
        entries = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        tick();
        #2;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
        n_cmp++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_rd: got %b want 0", fifo_rd); end
        n_cmp++; if (count !== 6'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_wr: got %b want 0", fifo_wr); end
        tick();
        reset   = 1'b0;
        req     = 4'b0000;
        cons_rd = 1'b0;
        #2;
        n_cmp++; if (fifo_entry !== 16'h0000) begin n_fail++; $display("FAIL rst_entry: got %h want 0000", fifo_entry); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
    endtask

    task automatic test_single_word();
        do_reset();
        req = 4'b0001;
        entries[15:0] = 16'h1234;
        #2;
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", grant); end
        tick();
        req = 4'b0000;
        #2;
        n_cmp++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL single_wr: got %b want 1", fifo_wr); end
        n_cmp++; if (fifo_entry !== 16'h1234) begin n_fail++; $display("FAIL single_entry: got %h want 1234", fifo_entry); end
        n_cmp++; if (count !== 6'd0) begin n_fail++; $display("FAIL single_count0: got %0d want 0", count); end
        tick();
        cons_rd = 1'b1;
        #2;
        n_cmp++; if (count !== 6'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", count); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", empty); end
        n_cmp++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL single_rd: got %b want 1", fifo_rd); end
        tick();
        cons_rd = 1'b0;
        #2;
        n_cmp++; if (count !== 6'd0) begin n_fail++; $display("FAIL single_drain: got %0d want 0", count); end
        n_cmp++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL single_wr_off: got %b want 0", fifo_wr); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        req     = 4'b1111;
        entries = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            #2;
            exp = 4'b0001 << ((k / MAXB) % 4);
            n_cmp++; if (grant !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp); end
        end
    endtask

    task automatic test_release();
        int         exp_own[11] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3};
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) tick();
            if (k == 6) req = 4'b1101;
            #2;
            exp = 4'b0001 << exp_own[k];
            n_cmp++; if (grant !== exp) begin n_fail++; $display("FAIL release_grant[%0d]: got %b want %b", k, grant, exp); end
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp;
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 34; k++) begin
            if (k > 0) tick();
            entries[15:0] = 16'(16'h5000 + k);
            #2;
            exp = (k < DEPTH) ? 4'b0001 : 4'b0000;
            n_cmp++; if (grant !== exp) begin n_fail++; $display("FAIL fill_grant[%0d]: got %b want %b", k, grant, exp); end
            n_cmp++; if (full !== (k >= DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", k, full, (k >= DEPTH)); end
        end
        n_cmp++; if (count !== 6'd32) begin n_fail++; $display("FAIL fill_count: got %0d want 32", count); end
    endtask

    // Continues from the full FIFO left by test_fill with req=0001 held.
    task automatic test_boundary();
        tick();
        cons_rd = 1'b1;
        #2;
        n_cmp++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL bnd_rd_full: got %b want 1", fifo_rd); end
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL bnd_grant_full: got %b want 0000", grant); end
        tick();
        cons_rd = 1'b0;
        #2;
        n_cmp++; if (count !== 6'd31) begin n_fail++; $display("FAIL bnd_count_a: got %0d want 31", count); end
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL bnd_grant_resume: got %b want 0001", grant); end
        tick();
        cons_rd = 1'b1;
        #2;
        n_cmp++; if (fifo_wr !== 1'b1) begin n_fail++; $display("FAIL bnd_wr: got %b want 1", fifo_wr); end
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL bnd_grant_simul: got %b want 0000", grant); end
        n_cmp++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL bnd_rd_simul: got %b want 1", fifo_rd); end
        tick();
        cons_rd = 1'b0;
        req     = 4'b0000;
        #2;
        n_cmp++; if (count !== 6'd31) begin n_fail++; $display("FAIL bnd_count_b: got %0d want 31", count); end
    endtask

    task automatic test_empty_read();
        do_reset();
        cons_rd = 1'b1;
        req     = 4'b0001;
        entries[15:0] = 16'hBEEF;
        #2;
        n_cmp++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL er_rd_n: got %b want 0", fifo_rd); end
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL er_grant: got %b want 0001", grant); end
        tick();
        req = 4'b0000;
        #2;
        n_cmp++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL er_rd_n1: got %b want 0", fifo_rd); end
        tick();
        #2;
        n_cmp++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL er_rd_n2: got %b want 1", fifo_rd); end
        tick();
        #2;
        n_cmp++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL er_rd_n3: got %b want 0", fifo_rd); end
        n_cmp++; if (count !== 6'd0) begin n_fail++; $display("FAIL er_count: got %0d want 0", count); end
        cons_rd = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 10; k++) tick();
        #2;
        // Cycle 10: producer 2 owns the port with two words already accepted.
        n_cmp++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL ar_pre_grant: got %b want 0100", grant); end
        n_cmp++; if (count !== 6'd9) begin n_fail++; $display("FAIL ar_pre_count: got %0d want 9", count); end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL ar_grant: got %b want 0000", grant); end
        n_cmp++; if (fifo_wr !== 1'b0) begin n_fail++; $display("FAIL ar_wr: got %b want 0", fifo_wr); end
        n_cmp++; if (count !== 6'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", count); end
        tick();
        reset = 1'b0;
        #2;
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL ar_after: got %b want 0001", grant); end
        req = 4'b0000;
    endtask

    task automatic test_random();
        logic [BN-1:0] m_q[$];
        bit            m_owned;
        int            m_owner;
        int            m_burst;
        int            m_rr;
        bit            m_wr;
        logic [BN-1:0] m_entry;
        logic [3:0]    p_req;
        logic [BN-1:0] p_data[4];
        logic [3:0]    e_grant;
        logic [3:0]    prev_grant;
        bit            e_rd;
        bit            space;
        int            cand;
        int            rd_pct;

        do_reset();
        m_q.delete();
        m_owned = 0; m_owner = 0; m_burst = 0; m_rr = 0; m_wr = 0; m_entry = '0;
        prev_grant = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            p_req[i]  = 1'b0;
            p_data[i] = '0;
        end
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc > 0) tick();
            // Producers hold a word until granted, then may offer a fresh one.
            for (int i = 0; i < 4; i++) begin
                if (prev_grant[i] || !p_req[i]) begin
                    p_data[i] = 16'($urandom);
                    p_req[i]  = ($urandom_range(0, 99) < 60);
                end
                entries[i*BN +: BN] = p_data[i];
            end
            req = p_req;
            rd_pct  = (cyc < 300) ? 15 : (cyc < 600) ? 95 : 50;
            cons_rd = ($urandom_range(0, 99) < rd_pct);
            #2;

            space = (m_q.size() + int'(m_wr)) < DEPTH;
            cand  = -1;
            if (m_owned && p_req[m_owner]) cand = m_owner;
            else
                for (int j = 0; j < 4; j++)
                    if (cand < 0 && p_req[(m_rr + j) % 4]) cand = (m_rr + j) % 4;
            e_grant = (cand >= 0 && space) ? 4'(1 << cand) : 4'b0000;
            e_rd    = cons_rd && (m_q.size() > 0);

            n_cmp++; if (grant !== e_grant) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", cyc, grant, e_grant); end
            n_cmp++; if (fifo_rd !== e_rd) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %b want %b", cyc, fifo_rd, e_rd); end
            n_cmp++; if (fifo_wr !== m_wr) begin n_fail++; $display("FAIL rnd_wr[%0d]: got %b want %b", cyc, fifo_wr, m_wr); end
            if (m_wr) begin
                n_cmp++; if (fifo_entry !== m_entry) begin n_fail++; $display("FAIL rnd_entry[%0d]: got %h want %h", cyc, fifo_entry, m_entry); end
            end
            n_cmp++; if (count !== (FE+1)'(m_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc, count, m_q.size()); end
            n_cmp++; if (full !== !space) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", cyc, full, !space); end
            n_cmp++; if (empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d]: got %b want %b", cyc, empty, (m_q.size() == 0)); end

            // Model of the coming clock edge.
            if (e_rd) void'(m_q.pop_front());
            if (m_wr) m_q.push_back(m_entry);
            if (e_grant != 4'b0000) begin
                if (m_owned && cand == m_owner) begin
                    m_burst++;
                    if (m_burst == MAXB) begin
                        m_owned = 0;
                        m_rr    = (m_owner + 1) % 4;
                    end
                end else begin
                    m_owner = cand;
                    m_burst = 1;
                    m_rr    = (cand + 1) % 4;
                    m_owned = (MAXB > 1);
                end
                m_wr    = 1;
                m_entry = p_data[cand];
            end else begin
                if (m_owned && !p_req[m_owner]) m_owned = 0;
                m_wr = 0;
            end
            prev_grant = e_grant;
        end
        req     = 4'b0000;
        cons_rd = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        cons_rd = 1'b0;
        entries = '0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_release();
        test_fill();
        test_boundary();
        test_empty_read();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
